uart_num_parser: RTL and testbench

UART_NUM_PARSER -- requirements
Module: uart_num_parser

---
 rtl/uart_num_parser_if.sv | 25 ++
 rtl/uart_num_parser.sv | 211 +++++++++++++++++++++
 tb/tb_uart_num_parser.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_num_parser_if.sv
// Byte-in / number-out bundle for uart_num_parser.
// slave is the parser's view; master is the producer/consumer view.
interface uart_num_parser_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] num_data;
    logic                  num_last;
    logic                  num_valid;
    logic                  num_ready;
    logic                  err_char;
    logic                  err_range;
    logic                  err_drop;

    modport slave (
        input  rx_data, rx_valid, num_ready,
        output num_data, num_last, num_valid, err_char, err_range, err_drop
    );

    modport master (
        output rx_data, rx_valid, num_ready,
        input  num_data, num_last, num_valid, err_char, err_range, err_drop
    );
endinterface

// File: rtl/uart_num_parser.sv
// Parses signed decimal tokens from a UART byte stream into a small output FIFO.
// Define PARSER_SATURATE_EN to clamp out-of-range tokens instead of discarding them.
module uart_num_parser #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_DIGITS = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_num_parser_if.slave  bus
);
    localparam int unsigned ACC_W  = DATA_WIDTH + 4;
    localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [ACC_W-1:0] POS_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MAX = POS_MAX + ACC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_SIGN, S_DIGITS, S_SKIP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ACC_W-1:0]      r_acc, w_acc_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic                  r_neg, w_neg_next;
    logic                  r_sat, w_sat_next;
    logic                  r_err_char, r_err_range, r_err_drop;
    logic                  w_err_char, w_err_range;
    logic                  w_emit;

    // Byte classification
    logic       w_is_digit, w_is_minus, w_is_delim;
    logic [3:0] w_digit;
    assign w_is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign w_is_minus = (bus.rx_data == 8'h2D);
    assign w_is_delim = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h09) ||
                        (bus.rx_data == 8'h2C) || (bus.rx_data == 8'h0D) ||
                        (bus.rx_data == 8'h0A);
    assign w_digit    = bus.rx_data[3:0];

    // Accumulator stays within the limit, so acc*10+9 never overflows ACC_W bits.
    logic [ACC_W-1:0] w_acc_mac, w_limit;
    logic             w_oor;
    assign w_acc_mac = (r_acc * ACC_W'(10)) + ACC_W'(w_digit);
    assign w_limit   = r_neg ? NEG_MAX : POS_MAX;
    assign w_oor     = (r_cnt >= CNT_W'(MAX_DIGITS)) || (w_acc_mac > w_limit);

    logic [DATA_WIDTH-1:0] w_mag, w_emit_data;
    logic                  w_emit_last;
    assign w_mag       = r_acc[DATA_WIDTH-1:0];
    assign w_emit_last = (bus.rx_data == 8'h0A);
    always_comb begin
        w_emit_data = r_neg ? (DATA_WIDTH'(0) - w_mag) : w_mag;
        if (r_sat)
            w_emit_data = r_neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        if (bus.rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_minus)      w_state_next = S_SIGN;
                    else if (w_is_digit) w_state_next = S_DIGITS;
                    else if (!w_is_delim) w_state_next = S_SKIP;
                end
                S_SIGN: begin
                    if (w_is_digit)      w_state_next = S_DIGITS;
                    else if (w_is_delim) w_state_next = S_IDLE;
                    else                 w_state_next = S_SKIP;
                end
                S_DIGITS: begin
                    if (w_is_digit) begin
`ifdef PARSER_SATURATE_EN
                        w_state_next = S_DIGITS;
`else
                        if (w_oor) w_state_next = S_SKIP;
`endif
                    end else if (w_is_delim) w_state_next = S_IDLE;
                    else                     w_state_next = S_SKIP;
                end
                S_SKIP: begin
                    if (w_is_delim) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // FSM datapath and pulse outputs
    always_comb begin
        w_acc_next  = r_acc;
        w_cnt_next  = r_cnt;
        w_neg_next  = r_neg;
        w_sat_next  = r_sat;
        w_emit      = 1'b0;
        w_err_char  = 1'b0;
        w_err_range = 1'b0;
        if (bus.rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_minus) begin
                        w_neg_next = 1'b1;
                        w_acc_next = '0;
                        w_cnt_next = '0;
                        w_sat_next = 1'b0;
                    end else if (w_is_digit) begin
                        w_neg_next = 1'b0;
                        w_acc_next = ACC_W'(w_digit);
                        w_cnt_next = CNT_W'(1);
                        w_sat_next = 1'b0;
                    end else if (!w_is_delim) begin
                        w_err_char = 1'b1;
                    end
                end
                S_SIGN: begin
                    if (w_is_digit) begin
                        w_acc_next = ACC_W'(w_digit);
                        w_cnt_next = CNT_W'(1);
                    end else begin
                        w_err_char = 1'b1;
                    end
                end
                S_DIGITS: begin
                    if (w_is_digit) begin
                        if (!r_sat) begin
                            if (w_oor) begin
                                w_err_range = 1'b1;
`ifdef PARSER_SATURATE_EN
                                w_sat_next  = 1'b1;
`endif
                            end else begin
                                w_acc_next = w_acc_mac;
                                w_cnt_next = r_cnt + CNT_W'(1);
                            end
                        end
                    end else if (w_is_delim) begin
                        w_emit     = 1'b1;
                        w_sat_next = 1'b0;
                    end else begin
                        w_err_char = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO bookkeeping: a full FIFO still accepts a write when the head pops the same cycle.
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [FCNT_W-1:0]     r_count;
    logic                  w_num_valid, w_full, w_pop, w_push, w_drop;
    logic [DATA_WIDTH:0]   w_head;

    assign w_num_valid = (r_count != '0);
    assign w_full      = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_pop       = w_num_valid && bus.num_ready;
    assign w_push      = w_emit && (!w_full || w_pop);
    assign w_drop      = w_emit && w_full && !w_pop;
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_sat       <= 1'b0;
            r_err_char  <= 1'b0;
            r_err_range <= 1'b0;
            r_err_drop  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_acc       <= w_acc_next;
            r_cnt       <= w_cnt_next;
            r_neg       <= w_neg_next;
            r_sat       <= w_sat_next;
            r_err_char  <= w_err_char;
            r_err_range <= w_err_range;
            r_err_drop  <= w_drop;
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_emit_last, w_emit_data};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.num_data  = w_head[DATA_WIDTH-1:0];
    assign bus.num_last  = w_head[DATA_WIDTH];
    assign bus.num_valid = w_num_valid;
    assign bus.err_char  = r_err_char;
    assign bus.err_range = r_err_range;
    assign bus.err_drop  = r_err_drop;
endmodule

// File: tb/tb_uart_num_parser.sv
// Directed bench for uart_num_parser: byte strings in, popped values and error pulses checked.
module tb_uart_num_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_char  = 0;
    int   n_range = 0;
    int   n_drop  = 0;
    logic [32:0] got_q [$];

    always #5 clk = ~clk;

    uart_num_parser_if #(.DATA_WIDTH(32)) bus ();

    uart_num_parser #(.DATA_WIDTH(32), .MAX_DIGITS(10), .FIFO_DEPTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Observe pops and error pulses between active edges
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.num_valid && bus.num_ready) got_q.push_back({bus.num_last, bus.num_data});
            if (bus.err_char)  n_char++;
            if (bus.err_range) n_range++;
            if (bus.err_drop)  n_drop++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    initial begin
        int qb, cb, rb, db;
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.num_ready = 1'b1;
        tick(2);
        check("rst_valid", 64'(bus.num_valid), 64'd0);
        check("rst_data",  64'(bus.num_data),  64'd0);
        check("rst_last",  64'(bus.num_last),  64'd0);
        check("rst_errs",  64'({bus.err_char, bus.err_range, bus.err_drop}), 64'd0);
        rst = 1'b0;
        tick(1);

        // "12 -7\n": one-cycle latency after each delimiter
        qb = got_q.size();
        send_str("12");
        check("lat_pre", 64'(bus.num_valid), 64'd0);
        send_byte(8'h20);
        check("lat_12_valid", 64'(bus.num_valid), 64'd1);
        check("lat_12_data",  64'(bus.num_data),  64'd12);
        check("lat_12_last",  64'(bus.num_last),  64'd0);
        send_str("-7\n");
        check("lat_m7_valid", 64'(bus.num_valid), 64'd1);
        check("lat_m7_data",  64'(bus.num_data),  64'hFFFF_FFF9);
        check("lat_m7_last",  64'(bus.num_last),  64'd1);
        tick(3);
        check("s1_count", 64'(got_q.size() - qb), 64'd2);
        check("s1_v0", 64'(got_q[qb]),   {31'd0, 1'b0, 32'd12});
        check("s1_v1", 64'(got_q[qb+1]), {31'd0, 1'b1, 32'hFFFF_FFF9});

        // Most-negative value and positive overflow by one
        qb = got_q.size(); rb = n_range;
        send_str("-2147483648,");
        tick(3);
        check("neg_min_count", 64'(got_q.size() - qb), 64'd1);
        check("neg_min_val",   64'(got_q[qb]), {31'd0, 1'b0, 32'h8000_0000});
        check("neg_min_range", 64'(n_range - rb), 64'd0);
        qb = got_q.size(); rb = n_range;
        send_str("2147483648,");
        tick(3);
        check("pos_ovf_range", 64'(n_range - rb), 64'd1);
`ifdef PARSER_SATURATE_EN
        check("pos_ovf_count", 64'(got_q.size() - qb), 64'd1);
        check("pos_ovf_val",   64'(got_q[qb]), {31'd0, 1'b0, 32'h7FFF_FFFF});
`else
        check("pos_ovf_count", 64'(got_q.size() - qb), 64'd0);
`endif

        // Eleven digits exceeds MAX_DIGITS even though the value is small
        qb = got_q.size(); rb = n_range;
        send_str("00000000001\n");
        tick(3);
        check("digits_range", 64'(n_range - rb), 64'd1);
`ifdef PARSER_SATURATE_EN
        check("digits_count", 64'(got_q.size() - qb), 64'd1);
        check("digits_val",   64'(got_q[qb]), {31'd0, 1'b1, 32'h7FFF_FFFF});
`else
        check("digits_count", 64'(got_q.size() - qb), 64'd0);
`endif

        // Malformed tokens
        qb = got_q.size(); cb = n_char;
        send_str("1a3 5,");
        tick(3);
        check("bad1_char",  64'(n_char - cb), 64'd1);
        check("bad1_count", 64'(got_q.size() - qb), 64'd1);
        check("bad1_val",   64'(got_q[qb]), {31'd0, 1'b0, 32'd5});
        qb = got_q.size(); cb = n_char;
        send_str("- ,");
        tick(3);
        check("bad2_char",  64'(n_char - cb), 64'd1);
        check("bad2_count", 64'(got_q.size() - qb), 64'd0);

        // Fill with consumer stalled, drop the fifth, then simultaneous pop/push of 9
        qb = got_q.size(); db = n_drop;
        bus.num_ready = 1'b0;
        send_str("1 2 3 4 5 ");
        tick(2);
        check("full_drop",  64'(n_drop - db), 64'd1);
        check("full_valid", 64'(bus.num_valid), 64'd1);
        check("full_head",  64'(bus.num_data), 64'd1);
        check("full_nopop", 64'(got_q.size() - qb), 64'd0);
        send_byte(8'h39);
        bus.num_ready = 1'b1;
        send_byte(8'h20);
        tick(6);
        check("fw_drop",  64'(n_drop - db), 64'd1);
        check("fw_count", 64'(got_q.size() - qb), 64'd5);
        for (int i = 0; i < 4; i++)
            check($sformatf("fw_order%0d", i), 64'(got_q[qb+i]), {31'd0, 1'b0, 32'(i + 1)});
        check("fw_last9", 64'(got_q[qb+4]), {31'd0, 1'b0, 32'd9});
        check("fw_empty", 64'(bus.num_valid), 64'd0);

        // Reset mid-token with two entries buffered
        bus.num_ready = 1'b0;
        send_str("1 2 45");
        check("pre_rst_valid", 64'(bus.num_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(bus.num_valid), 64'd0);
        check("rst_async_data",  64'(bus.num_data),  64'd0);
        tick(2);
        rst = 1'b0;
        qb = got_q.size();
        bus.num_ready = 1'b1;
        send_str("6\n");
        tick(3);
        check("post_rst_count", 64'(got_q.size() - qb), 64'd1);
        check("post_rst_val",   64'(got_q[qb]), {31'd0, 1'b1, 32'd6});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
